// File: rtl/ifm_buf_loader_pkg.sv
// Shared definitions for the IFM row loader.
//   - Sizing constants shared with the CNN controller (row/width/channel
//     widths, DRAM address/data widths, line-buffer geometry, burst length).
//   - FSM state encoding (2 bits).
//   - Captured load-request record (row index plus the configuration that
//     was live when the request arrived).
//   - row_words(): width * channel computed at full product width, then
//     truncated to the burst-length width.
package ifm_buf_loader_pkg;

  localparam int W_SIZE        = 9;
  localparam int W_CHANNEL     = 5;
  localparam int W_ADDR        = 32;
  localparam int W_DATA        = 32;
  localparam int NUM_LINES     = 3;
  localparam int MAX_ROW_WORDS = 1024;
  localparam int W_BUF_ADDR    = 12;
  localparam int W_LEN         = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [W_SIZE-1:0]    row;
    logic [W_SIZE-1:0]    width;
    logic [W_CHANNEL-1:0] channel;
    logic [W_ADDR-1:0]    base;
  } load_req_t;

  function automatic logic [W_LEN-1:0] row_words(input logic [W_SIZE-1:0]    w,
                                                 input logic [W_CHANNEL-1:0] c);
    localparam int W_PROD = W_SIZE + W_CHANNEL;
    logic [W_PROD-1:0] p;
    p = W_PROD'(w) * W_PROD'(c);
    return W_LEN'(p);
  endfunction

endpackage

// File: rtl/ifm_req_queue.sv
// One-deep pending load-request slot with sticky overflow flag.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   push_i, req_i  offer a request to the slot
//   pop_i          the loader consumes the held request this cycle
//   full_o, req_o  slot occupancy and held request
//   overflow_o     sticky: a push arrived while the slot was full and not
//                  being drained; cleared only by reset
module ifm_req_queue
  import ifm_buf_loader_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      push_i,
  input  load_req_t req_i,
  input  logic      pop_i,
  output logic      full_o,
  output load_req_t req_o,
  output logic      overflow_o
);

  logic      full_q, full_d;
  logic      ovf_q, ovf_d;
  load_req_t req_q;
  logic      accept;

  // A pop in the same cycle frees the slot, so a simultaneous push is kept.
  assign accept = push_i && (!full_q || pop_i);

  always_comb begin
    full_d = full_q;
    ovf_d  = ovf_q;
    if (accept)     full_d = 1'b1;
    else if (pop_i) full_d = 1'b0;
    if (push_i && full_q && !pop_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_q <= req_i;
  end

  assign full_o     = full_q;
  assign req_o      = req_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ifm_buf_loader.sv
// IFM row loader: accepts a row-load request from the CNN controller, issues
// one DRAM burst read for the whole row (width * channel words), writes each
// returned beat into its slot of the circular line buffer, and pulses done.
// Ports:
//   clk, rstn                               clock, async active-low reset
//   q_width, q_channel, q_base_addr         live layer configuration
//   i_req_load, i_req_row                   load request pulse + row index
//   o_rd_req, o_rd_addr, o_rd_len, i_rd_ack burst read request handshake
//   i_rd_valid, i_rd_data                   returned read beats
//   o_buf_we, o_buf_addr, o_buf_wdata       line-buffer write port
//   o_ifm_buf_done                          one-cycle row-loaded pulse
//   o_busy                                  load in progress
//   o_req_overflow                          sticky dropped-request flag
module ifm_buf_loader
  import ifm_buf_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [W_SIZE-1:0]     q_width,
  input  logic [W_CHANNEL-1:0]  q_channel,
  input  logic [W_ADDR-1:0]     q_base_addr,
  input  logic                  i_req_load,
  input  logic [W_SIZE-1:0]     i_req_row,
  output logic                  o_rd_req,
  output logic [W_ADDR-1:0]     o_rd_addr,
  output logic [W_LEN-1:0]      o_rd_len,
  input  logic                  i_rd_ack,
  input  logic                  i_rd_valid,
  input  logic [W_DATA-1:0]     i_rd_data,
  output logic                  o_buf_we,
  output logic [W_BUF_ADDR-1:0] o_buf_addr,
  output logic [W_DATA-1:0]     o_buf_wdata,
  output logic                  o_ifm_buf_done,
  output logic                  o_busy,
  output logic                  o_req_overflow
);

  state_e                state_q, state_d;
  load_req_t             in_req, pend_req, src_req;
  logic                  pend_full, push, pop, start;
  logic [W_LEN-1:0]      start_len;
  logic [W_ADDR-1:0]     start_addr;
  logic [W_BUF_ADDR-1:0] start_slot;

  logic [W_ADDR-1:0]     rd_addr_q;
  logic [W_LEN-1:0]      rd_len_q;
  logic [W_LEN-1:0]      beat_idx_q;
  logic [W_BUF_ADDR-1:0] slot_base_q;
  logic                  we_q, last_q;
  logic [W_BUF_ADDR-1:0] buf_addr_q;
  logic [W_DATA-1:0]     wdata_q;
  logic                  beat_fire, beat_last;

  assign in_req = '{row: i_req_row, width: q_width, channel: q_channel, base: q_base_addr};

  // A request that lands in the DONE cycle with an empty slot is parked and
  // then picked up from IDLE, so IDLE serves the pending slot before any new
  // request to keep arrival order.
  assign src_req = pend_full ? pend_req : in_req;
  assign start   = ((state_q == S_IDLE) && (pend_full || i_req_load)) ||
                   ((state_q == S_DONE) && pend_full);
  assign pop     = start && pend_full;
  assign push    = i_req_load && !((state_q == S_IDLE) && !pend_full);

  ifm_req_queue u_req_queue (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (push),
    .req_i      (in_req),
    .pop_i      (pop),
    .full_o     (pend_full),
    .req_o      (pend_req),
    .overflow_o (o_req_overflow)
  );

  assign start_len  = row_words(src_req.width, src_req.channel);
  assign start_addr = src_req.base + (W_ADDR'(src_req.row) * W_ADDR'(start_len));
  assign start_slot = W_BUF_ADDR'((int'(src_req.row) % NUM_LINES) * MAX_ROW_WORDS);

  // Beats beyond the row length (or outside DATA) are ignored.
  assign beat_fire = (state_q == S_DATA) && i_rd_valid && (beat_idx_q != rd_len_q);
  assign beat_last = (beat_idx_q == rd_len_q - W_LEN'(1));

  always_comb begin
    state_d        = state_q;
    o_rd_req       = 1'b0;
    o_busy         = (state_q != S_IDLE);
    o_ifm_buf_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        // Zero-length rows pass through REQ without issuing a burst.
        o_rd_req = (rd_len_q != '0);
        if (rd_len_q == '0) state_d = S_DONE;
        else if (i_rd_ack)  state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q && last_q) state_d = S_DONE;
      end
      S_DONE: begin
        o_ifm_buf_done = 1'b1;
        state_d        = pend_full ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      beat_idx_q <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      buf_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      we_q   <= beat_fire;
      last_q <= beat_fire && beat_last;
      if (start) begin
        rd_addr_q  <= start_addr;
        rd_len_q   <= start_len;
        beat_idx_q <= '0;
      end else if (beat_fire) begin
        beat_idx_q <= beat_idx_q + W_LEN'(1);
      end
      if (beat_fire) begin
        buf_addr_q <= slot_base_q + W_BUF_ADDR'(beat_idx_q);
        wdata_q    <= i_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) slot_base_q <= start_slot;
  end

  assign o_rd_addr   = rd_addr_q;
  assign o_rd_len    = rd_len_q;
  assign o_buf_we    = we_q;
  assign o_buf_addr  = buf_addr_q;
  assign o_buf_wdata = wdata_q;

endmodule

// File: tb/tb_ifm_buf_loader.sv
module tb_ifm_buf_loader;
  import ifm_buf_loader_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [W_SIZE-1:0]     q_width;
  logic [W_CHANNEL-1:0]  q_channel;
  logic [W_ADDR-1:0]     q_base_addr;
  logic                  i_req_load;
  logic [W_SIZE-1:0]     i_req_row;
  logic                  o_rd_req;
  logic [W_ADDR-1:0]     o_rd_addr;
  logic [W_LEN-1:0]      o_rd_len;
  logic                  i_rd_ack;
  logic                  i_rd_valid;
  logic [W_DATA-1:0]     i_rd_data;
  logic                  o_buf_we;
  logic [W_BUF_ADDR-1:0] o_buf_addr;
  logic [W_DATA-1:0]     o_buf_wdata;
  logic                  o_ifm_buf_done;
  logic                  o_busy;
  logic                  o_req_overflow;

  ifm_buf_loader dut (
    .clk(clk), .rstn(rstn), .q_width(q_width), .q_channel(q_channel),
    .q_base_addr(q_base_addr), .i_req_load(i_req_load), .i_req_row(i_req_row),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .i_rd_ack(i_rd_ack), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
    .o_ifm_buf_done(o_ifm_buf_done), .o_busy(o_busy), .o_req_overflow(o_req_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations
  logic [W_ADDR-1:0]     obs_addr[$];
  logic [W_LEN-1:0]      obs_len[$];
  logic [W_BUF_ADDR-1:0] wr_addr[$];
  logic [W_DATA-1:0]     wr_data[$];
  logic [W_DATA-1:0]     sent[$];
  int                    done_cyc[$];
  int                    req_cyc[$];
  int                    rdreq_cnt = 0;
  int                    req_unstable = 0;
  int                    last_beat_cyc = 0;
  logic                  prev_rdreq = 1'b0;

  // Reference model expectations
  logic [W_ADDR-1:0]     exp_addr[$];
  logic [W_LEN-1:0]      exp_len[$];
  logic [W_BUF_ADDR-1:0] exp_sbase[$];
  int                    resp_len[$];

  // DRAM responder controls (written by main only)
  int ack_dly = 0;
  int gap     = 0;
  int extra_req = 0;
  int extra_done = 0;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (o_buf_we) begin
        wr_addr.push_back(o_buf_addr);
        wr_data.push_back(o_buf_wdata);
      end
      if (o_ifm_buf_done) done_cyc.push_back(cyc);
      if (o_rd_req) rdreq_cnt++;
      if (o_rd_req && !prev_rdreq) req_cyc.push_back(cyc);
      prev_rdreq = o_rd_req;
    end else begin
      prev_rdreq = 1'b0;
    end
  end

  // DRAM read-port model: acks each burst after ack_dly cycles, then returns
  // the number of beats the reference model says the row holds.
  initial begin
    int n;
    i_rd_ack = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
    forever begin
      @(negedge clk);
      if (extra_req != extra_done) begin
        extra_done++;
        i_rd_valid = 1'b1; i_rd_data = $urandom;
        @(negedge clk);
        i_rd_valid = 1'b0;
      end else if (rstn && o_rd_req) begin
        obs_addr.push_back(o_rd_addr);
        obs_len.push_back(o_rd_len);
        for (int d = 0; d < ack_dly; d++) begin
          @(negedge clk);
          if (o_rd_req !== 1'b1 || o_rd_addr !== obs_addr[$] || o_rd_len !== obs_len[$])
            req_unstable++;
        end
        i_rd_ack = 1'b1;
        @(negedge clk);
        i_rd_ack = 1'b0;
        n = (resp_len.size() > 0) ? resp_len.pop_front() : 0;
        for (int b = 0; b < n && rstn; b++) begin
          i_rd_valid = 1'b1; i_rd_data = $urandom;
          sent.push_back(i_rd_data);
          last_beat_cyc = cyc;
          @(negedge clk);
          i_rd_valid = 1'b0;
          if (b < n - 1)
            for (int g = 0; g < gap && rstn; g++) @(negedge clk);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    obs_addr.delete(); obs_len.delete(); wr_addr.delete(); wr_data.delete();
    sent.delete(); done_cyc.delete(); req_cyc.delete(); resp_len.delete();
    exp_addr.delete(); exp_len.delete(); exp_sbase.delete();
    rdreq_cnt = 0; req_unstable = 0;
  endtask

  // Reference model: one burst of width*channel (mod 2^11) words at
  // base + row*len, landing in slot (row mod 3) of the line buffer.
  task automatic push_job(input int row, input int w, input int c, input logic [31:0] base);
    int len;
    len = (w * c) % 2048;
    if (len != 0) begin
      exp_len.push_back(W_LEN'(len));
      exp_addr.push_back(base + 32'(row * len));
      exp_sbase.push_back(W_BUF_ADDR'((row % 3) * 1024));
      resp_len.push_back(len);
    end
  endtask

  task automatic req(input int row, input int w, input int c, input logic [31:0] base,
                     output int at);
    @(negedge clk); #1;
    i_req_row = W_SIZE'(row); q_width = W_SIZE'(w); q_channel = W_CHANNEL'(c);
    q_base_addr = base; i_req_load = 1'b1;
    at = cyc;
    @(negedge clk); #1;
    i_req_load = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int t = 0;
    while (done_cyc.size() < n && t < budget) begin
      @(negedge clk); t++;
    end
    chk({tag, "_done_seen"}, done_cyc.size() >= n, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    int k = 0, bad = 0, total = 0;
    chk({tag, "_nbursts"}, obs_addr.size(), exp_addr.size());
    for (int j = 0; j < exp_addr.size(); j++) begin
      if (j < obs_addr.size()) begin
        chk({tag, "_rd_addr"}, obs_addr[j], exp_addr[j]);
        chk({tag, "_rd_len"}, obs_len[j], exp_len[j]);
      end
      for (int i = 0; i < int'(exp_len[j]); i++) begin
        if (k >= wr_addr.size() || k >= sent.size()) bad++;
        else if (wr_addr[k] !== exp_sbase[j] + W_BUF_ADDR'(i) || wr_data[k] !== sent[k]) bad++;
        k++;
      end
      total += int'(exp_len[j]);
    end
    chk({tag, "_n_writes"}, wr_addr.size(), total);
    chk({tag, "_write_errs"}, bad, 0);
    chk({tag, "_req_stable"}, req_unstable, 0);
  endtask

  initial begin
    int at, t;
    logic [31:0] base;
    rstn = 1'b0; i_req_load = 1'b0; i_req_row = '0;
    q_width = '0; q_channel = '0; q_base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_req", o_rd_req, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_buf_we", o_buf_we, 0);
    chk("rst_done", o_ifm_buf_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_req_overflow, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Full-size row: 256 x 4 words, row 5 -> slot 2.
    clear_all(); ack_dly = 3; gap = 0;
    push_job(5, 256, 4, 32'h1000_0000);
    req(5, 256, 4, 32'h1000_0000, at);
    chk("t1_busy", o_busy, 1);
    wait_done(1, 3000, "t1");
    check_stream("t1");
    chk("t1_addr_const", obs_addr.size() > 0 ? obs_addr[0] : 32'h0, 32'h1000_1400);
    chk("t1_first_buf_addr", wr_addr.size() > 0 ? wr_addr[0] : 12'h0, 12'd2048);
    chk("t1_last_buf_addr", wr_addr.size() > 0 ? wr_addr[$] : 12'h0, 12'd3071);
    chk("t1_done_count", done_cyc.size(), 1);
    chk("t1_done_latency", done_cyc.size() > 0 ? done_cyc[0] - last_beat_cyc : -1, 2);
    chk("t1_idle_after", o_busy, 0);

    // Rows 0..3 back to back (4 x 2): slots 0,1,2,0.
    clear_all(); ack_dly = 1; gap = 0; base = $urandom;
    for (int r = 0; r < 4; r++) begin
      push_job(r, 4, 2, base);
      req(r, 4, 2, base, at);
      wait_done(r + 1, 200, "t2");
    end
    check_stream("t2");
    chk("t2_done_count", done_cyc.size(), 4);

    // Gapped beats, then a stray beat after done.
    clear_all(); ack_dly = 2; gap = 2; base = $urandom;
    t = $urandom_range(0, 255);
    push_job(t, 8, 1, base);
    req(t, 8, 1, base, at);
    wait_done(1, 300, "t3");
    extra_req++;
    repeat (6) @(negedge clk);
    check_stream("t3");
    chk("t3_done_count", done_cyc.size(), 1);

    // Pending request during DATA, third request overflows.
    clear_all(); ack_dly = 1; gap = 2; base = $urandom;
    push_job(0, 8, 1, base);
    push_job(1, 4, 2, base);
    req(0, 8, 1, base, at);
    t = 0;
    while (wr_addr.size() < 2 && t < 200) begin @(negedge clk); t++; end
    chk("t4_in_data", wr_addr.size() >= 2, 1);
    req(1, 4, 2, base, at);
    chk("t4_ovf_after_pend", o_req_overflow, 0);
    req(2, 4, 2, base, at);
    chk("t4_ovf_set", o_req_overflow, 1);
    wait_done(2, 400, "t4");
    repeat (20) @(negedge clk);
    check_stream("t4");
    chk("t4_done_count", done_cyc.size(), 2);
    chk("t4_req_after_done", (done_cyc.size() > 0 && req_cyc.size() > 1) ?
        req_cyc[1] - done_cyc[0] : -1, 1);
    chk("t4_ovf_sticky", o_req_overflow, 1);

    // Zero-width row: no burst, no writes, done two cycles after request.
    clear_all(); ack_dly = 0; gap = 0;
    req(3, 0, 4, 32'h0, at);
    wait_done(1, 20, "t5");
    chk("t5_done_latency", done_cyc.size() > 0 ? done_cyc[0] - at : -1, 2);
    chk("t5_no_rd_req", rdreq_cnt, 0);
    chk("t5_no_writes", wr_addr.size(), 0);

    // Randomised rows.
    for (int k = 0; k < 3; k++) begin
      int rr, ww, cc;
      clear_all(); ack_dly = $urandom_range(0, 4); gap = $urandom_range(0, 1);
      base = $urandom; rr = $urandom_range(0, 255);
      ww = $urandom_range(1, 16); cc = $urandom_range(1, 8);
      push_job(rr, ww, cc, base);
      req(rr, ww, cc, base, at);
      wait_done(1, 600, "rnd");
      check_stream("rnd");
    end

    // Reset in the middle of a 1024-beat burst.
    clear_all(); ack_dly = 0; gap = 0;
    push_job(7, 256, 4, 32'h2000_0000);
    req(7, 256, 4, 32'h2000_0000, at);
    t = 0;
    while (wr_addr.size() < 100 && t < 2000) begin @(negedge clk); t++; end
    chk("t6_reached_100", wr_addr.size() >= 100, 1);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_rd_req", o_rd_req, 0);
    chk("t6_rst_rd_addr", o_rd_addr, 0);
    chk("t6_rst_rd_len", o_rd_len, 0);
    chk("t6_rst_buf_we", o_buf_we, 0);
    chk("t6_rst_buf_addr", o_buf_addr, 0);
    chk("t6_rst_buf_wdata", o_buf_wdata, 0);
    chk("t6_rst_done", o_ifm_buf_done, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_ovf", o_req_overflow, 0);
    repeat (3) @(negedge clk);
    #1 clear_all();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    base = $urandom;
    push_job(4, 4, 2, base);
    req(4, 4, 2, base, at);
    wait_done(1, 200, "t6");
    check_stream("t6");
    chk("t6_restart_addr", wr_addr.size() > 0 ? wr_addr[0] : 12'hfff, 12'd1024);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
